rv_div_unit: RTL and testbench



---
 rtl/rv_div_if.sv | 28 ++
 rtl/rv_div_unit.sv | 177 +++++++++++++++++
 tb/tb_rv_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rv_div_if.sv
// rv_div_if: request / write-back bundle between issue logic, the divide unit
// and the register file write port.
//   start, op, rd_addr, src_a, src_b : request (master -> slave)
//   busy                             : unit occupied (slave -> master)
//   wb_we, wb_addr, wb_data          : register file write port (slave -> master)
interface rv_div_if #(
   parameter int unsigned XLEN = 32
);
   logic             start;
   logic [1:0]       op;
   logic [4:0]       rd_addr;
   logic [XLEN-1:0]  src_a;
   logic [XLEN-1:0]  src_b;
   logic             busy;
   logic             wb_we;
   logic [4:0]       wb_addr;
   logic [XLEN-1:0]  wb_data;

   modport master (
      output start, op, rd_addr, src_a, src_b,
      input  busy, wb_we, wb_addr, wb_data
   );

   modport slave (
      input  start, op, rd_addr, src_a, src_b,
      output busy, wb_we, wb_addr, wb_data
   );
endinterface

// File: rtl/rv_div_unit.sv
// rv_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring,
// one quotient bit per clock.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rv_div_if slave (start/op/rd_addr/src_a/src_b in,
//          busy/wb_we/wb_addr/wb_data out, all outputs registered)
module rv_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   rv_div_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out / quotient shifting in
   logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder, or preset result on the fast path
   logic [XLEN-1:0]   dvs_q, dvs_d;     // absolute divisor
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic              is_rem_q, is_rem_d;
   logic              fast_q, fast_d;
   logic [4:0]        rd_q, rd_d;
   logic              busy_q, busy_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;

   logic              is_signed, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     shifted, diff;
   logic [XLEN-1:0]   quo_step, rem_step, res_fix;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         fast_q    <= 1'b0;
         rd_q      <= '0;
         busy_q    <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         fast_q    <= fast_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   // Next-state, restoring step and write-back
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      fast_d    = fast_q;
      rd_d      = rd_q;
      busy_d    = busy_q;
      wb_we_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;

      // Operand conditioning; |-2^(XLEN-1)| is representable as unsigned
      is_signed = ~bus.op[0];
      a_neg     = is_signed & bus.src_a[XLEN-1];
      b_neg     = is_signed & bus.src_b[XLEN-1];
      a_abs     = a_neg ? XLEN'(-bus.src_a) : bus.src_a;
      b_abs     = b_neg ? XLEN'(-bus.src_b) : bus.src_b;
      div_zero  = (bus.src_b == '0);
      ovf       = is_signed & (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src_b == '1);

      // One restoring step; diff[XLEN] is the borrow (trial subtract failed)
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      if (diff[XLEN]) begin
         rem_step = shifted[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b0};
      end else begin
         rem_step = diff[XLEN-1:0];
         quo_step = {quo_q[XLEN-2:0], 1'b1};
      end

      // Sign correction applied to the values produced by the final step
      if (is_rem_q) begin
         res_fix = neg_rem_q ? XLEN'(-rem_step) : rem_step;
      end else begin
         res_fix = neg_quo_q ? XLEN'(-quo_step) : quo_step;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_CALC;
               busy_d    = 1'b1;
               cnt_d     = '0;
               quo_d     = a_abs;
               dvs_d     = b_abs;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               is_rem_d  = bus.op[1];
               rd_d      = bus.rd_addr;
               fast_d    = div_zero | ovf;
               // Fast-path result is preset into the remainder register
               if (div_zero) begin
                  rem_d = bus.op[1] ? bus.src_a : '1;
               end else if (ovf) begin
                  rem_d = bus.op[1] ? '0 : bus.src_a;
               end else begin
                  rem_d = '0;
               end
            end
         end
         S_CALC: begin
            if (fast_q) begin
               state_d   = S_DONE;
               wb_we_d   = (rd_q != '0);
               wb_addr_d = rd_q;
               wb_data_d = rem_q;
            end else begin
               quo_d = quo_step;
               rem_d = rem_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  state_d   = S_DONE;
                  wb_we_d   = (rd_q != '0);
                  wb_addr_d = rd_q;
                  wb_data_d = res_fix;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.wb_we   = wb_we_q;
   assign bus.wb_addr = wb_addr_q;
   assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_rv_div_unit.sv
// tb_rv_div_unit: randomized + directed stimulus for rv_div_unit; expected
// write-backs (address, data, cycle) are queued at issue and checked by an
// independent monitor when wb_we is seen.
module tb_rv_div_unit;
   localparam int unsigned XLEN = 32;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv_div_if #(.XLEN(XLEN)) bus ();
   rv_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: RV32M semantics via plain integer arithmetic
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sbv, q, r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         q   = sa / sbv;
         r   = sa % sbv;
         return op[1] ? 32'(r) : 32'(q);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   // Monitor: every wb_we pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.wb_we === 1'b1) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wb: addr %0d data %h", bus.wb_addr, bus.wb_data);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("wb_addr", 64'(bus.wb_addr), 64'(e.addr));
            chk("wb_data", 64'(bus.wb_data), 64'(e.data));
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Called at a negedge; start is sampled at the following posedge
   task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input bit expect_wb, output int busy_len);
      bit   fast;
      exp_t e;
      fast = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      busy_len = fast ? 2 : int'(XLEN) + 1;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rd_addr = rd;
      bus.src_a   = a;
      bus.src_b   = b;
      if (expect_wb && rd != 5'd0) begin
         e.addr = rd;
         e.data = ref_res(op, a, b);
         e.cyc  = cyc + 1 + (fast ? 1 : int'(XLEN));
         sbq.push_back(e);
      end
      @(negedge clk);
      bus.start   = 1'b0;
      bus.src_a   = $urandom;
      bus.src_b   = $urandom;
      bus.op      = 2'($urandom);
      bus.rd_addr = 5'($urandom);
   endtask

   task automatic wait_idle(input int exp_n);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("busy_len", 64'(n), 64'(exp_n));
   endtask

   task automatic run(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                      input logic [31:0] b);
      int bl;
      issue(op, rd, a, b, 1'b1, bl);
      wait_idle(bl);
   endtask

   initial begin
      int bl;
      int n;
      logic [1:0]  rop;
      logic [4:0]  rrd;
      logic [31:0] ra, rb;

      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.rd_addr = 5'd0; bus.src_a = '0; bus.src_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_wb_we", 64'(bus.wb_we), 64'(0));
      chk("rst_wb_addr", 64'(bus.wb_addr), 64'(0));
      chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
      rst = 1'b0;

      // Directed cases
      run(OP_DIVU, 5'd5, 32'd100, 32'd7);
      run(OP_REMU, 5'd5, 32'd100, 32'd7);
      run(OP_DIV,  5'd6, 32'hFFFF_FFF9, 32'd2);
      run(OP_REM,  5'd6, 32'hFFFF_FFF9, 32'd2);
      run(OP_REM,  5'd8, 32'd7, 32'hFFFF_FFFE);
      run(OP_DIVU, 5'd9, 32'd1234, 32'd0);
      run(OP_REM,  5'd9, 32'd1234, 32'd0);
      run(OP_DIV,  5'd10, 32'h8000_0000, 32'hFFFF_FFFF);
      run(OP_REM,  5'd10, 32'h8000_0000, 32'hFFFF_FFFF);

      // Starts during CALC and DONE are ignored; next IDLE start accepted
      issue(OP_DIVU, 5'd3, 32'd1000, 32'd10, 1'b1, bl);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIV; bus.rd_addr = 5'd12; bus.src_a = 32'd55; bus.src_b = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.wb_we !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wait_wb_timeout", 64'(n < 100), 64'(1));
      bus.start = 1'b1; bus.op = OP_REMU; bus.rd_addr = 5'd13; bus.src_a = 32'd99; bus.src_b = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("idle_after_done", 64'(bus.busy), 64'(0));
      run(OP_DIVU, 5'd4, 32'd77, 32'd7);

      // Reset in the middle of CALC discards the operation
      issue(OP_DIVU, 5'd6, 32'd5000, 32'd3, 1'b0, bl);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 64'(bus.busy), 64'(0));
      chk("mid_rst_wb_we", 64'(bus.wb_we), 64'(0));
      chk("mid_rst_wb_data", 64'(bus.wb_data), 64'(0));
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run(OP_DIVU, 5'd7, 32'd9, 32'd3);

      // rd=0 suppresses the write but keeps full busy timing; then back-to-back
      run(OP_DIVU, 5'd0, 32'd50, 32'd5);
      run(OP_DIVU, 5'd11, 32'hFFFF_FFFF, 32'd1);

      // Randomized operations
      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         rrd = 5'($urandom);
         ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = $urandom;
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run(rop, rrd, ra, rb);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
